game_tick_receiver: RTL

Fast-domain consumer of the divided game clock. Samples the slow square wave from the clock divider (half-period 20,000,000 `clk_in` cycles) and turns each selected transition into a single-cycle `tick` strobe. It also provides a pending/acknowledge handshake to the game-logic FSM, a wrapping frame counter, and a stall watchdog. Sits between the clock divider and all frame-rate game logic, so no game logic is ever clocked directly by the divided signal.

---
 rtl/game_tick_receiver.sv | 97 +++++++++
 1 files changed

// File: rtl/game_tick_receiver.sv
// Synchronizes the divided game clock into the clk_in domain and turns selected
// transitions into single-cycle ticks, with pending/ack handshake, frame counter and stall watchdog.
module game_tick_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int TIMEOUT     = 40000000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        slow_clk,
    input  logic        tick_ack,
    output logic        tick,
    output logic        tick_pending,
    output logic [15:0] tick_count,
    output logic        overrun,
    output logic        stalled
);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);

    typedef enum logic [1:0] {ARMING, RUN, STALL} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic [ARM_W-1:0]       arm_cnt, arm_next;
    logic [WD_W-1:0]        wd, wd_next;
    logic                   trans, qual, issue;

    assign trans   = sync[SYNC_STAGES-1] ^ prev;
    assign qual    = trans && ((EDGE_MODE == 1) || sync[SYNC_STAGES-1]);
    assign stalled = (state == STALL);

    always_ff @(posedge clk_in) begin
        if (!rst_n) state <= ARMING;
        else        state <= state_next;
    end

    // ARMING waits until the synchronizer and prev hold real samples, so a
    // slow_clk already high at reset release never looks like an edge.
    always_comb begin
        state_next = state;
        arm_next   = arm_cnt;
        wd_next    = wd;
        issue      = 1'b0;
        case (state)
            ARMING: begin
                wd_next = '0;
                if (arm_cnt == ARM_LAST) state_next = RUN;
                else                     arm_next   = arm_cnt + ARM_W'(1);
            end
            RUN: begin
                issue = qual;
                if (trans)              wd_next = '0;
                else if (wd != WD_MAX)  wd_next = wd + WD_W'(1);
                if (!trans && wd_next == WD_MAX) state_next = STALL;
            end
            STALL: begin
                issue = qual;
                if (trans) begin
                    wd_next    = '0;
                    state_next = RUN;
                end
            end
            default: state_next = ARMING;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync         <= '0;
            prev         <= 1'b0;
            arm_cnt      <= '0;
            wd           <= '0;
            tick         <= 1'b0;
            tick_pending <= 1'b0;
            tick_count   <= '0;
            overrun      <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], slow_clk};
            prev    <= sync[SYNC_STAGES-1];
            arm_cnt <= arm_next;
            wd      <= wd_next;
            tick    <= issue;
            if (issue) begin
                tick_count   <= tick_count + 16'd1;
                tick_pending <= 1'b1;
                // an ack landing with the new tick retires the old one cleanly
                if (tick_pending && !tick_ack) overrun <= 1'b1;
            end else if (tick_ack) begin
                tick_pending <= 1'b0;
            end
        end
    end
endmodule
